// File: rtl/ext_irq_pkg.sv
// Shared definitions for the external interrupt controller:
// register offsets (addr[4:2]), FSM states and default source count.
package ext_irq_pkg;

    localparam int NSRC_DEFAULT = 8;

    // Register select values, taken from byte address bits [4:2]
    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_CLAIM    = 3'd2;
    localparam logic [2:0] REG_COMPLETE = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder.
// Ports: vec_i (request vector), id_o (lowest set index), valid_o (any set).
module irq_prio_enc #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] vec_i,
    output logic [4:0]      id_o,
    output logic            valid_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        id_o = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                id_o = 5'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge/level sources, enable mask,
// claim/complete handshake and a registered meip_o request to the core.
// Ports: clk_i, reset_i (sync, active-high), src_i[NSRC], register bus
// (wr_en_i, rd_en_i, addr_i[4:0], wdata_i, rdata_o), meip_o, irq_ack_i.
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int          NSRC      = NSRC_DEFAULT,
    parameter logic [31:0] EDGE_MASK = 32'h0000_00FF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NSRC-1:0] src_i,
    input  logic            wr_en_i,
    input  logic            rd_en_i,
    input  logic [4:0]      addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic            meip_o,
    input  logic            irq_ack_i
);

    localparam logic [NSRC-1:0] EMASK = EDGE_MASK[NSRC-1:0];

    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] pend_d;
    logic [NSRC-1:0] en_q;
    logic [NSRC-1:0] pend_vec;
    logic [NSRC-1:0] pe;
    logic [NSRC-1:0] evt;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] claim_clr;
    logic [4:0]      enc_id;
    logic            enc_v;
    logic [4:0]      claim_id_q;
    logic            claim_v_q;
    logic            meip_q;
    logic [31:0]     rdata_q;
    state_e          state_q;

    logic [2:0] sel;
    logic       wr_pend;
    logic       wr_en;
    logic       wr_comp;
    logic       claim_fire;
    logic       complete_hit;

    // Address bits [1:0] and upper write data are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign sel     = addr_i[4:2];
    assign wr_pend = wr_en_i && (sel == REG_PENDING);
    assign wr_en   = wr_en_i && (sel == REG_ENABLE);
    assign wr_comp = wr_en_i && (sel == REG_COMPLETE);

    // Level sources bypass the pending flops and follow src_i.
    assign pend_vec = (pend_q & EMASK) | (src_i & ~EMASK);
    assign pe       = pend_vec & en_q;

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_enc (
        .vec_i   (pe),
        .id_o    (enc_id),
        .valid_o (enc_v)
    );

    assign claim_fire   = (state_q == ST_REQ) && irq_ack_i && enc_v;
    assign complete_hit = (state_q == ST_SERVICE) && wr_comp
                          && (wdata_i[4:0] == claim_id_q);

    assign evt = src_i & ~src_q & EMASK;
    assign w1c = wr_pend ? wdata_i[NSRC-1:0] : '0;

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (claim_fire && (enc_id == 5'(i))) begin
                claim_clr[i] = 1'b1;
            end
        end
    end

    // A new event wins over a same-cycle clear of the same bit.
    assign pend_d = ((pend_q & ~w1c & ~claim_clr) | evt) & EMASK;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src_q  <= src_i;
            pend_q <= '0;
            en_q   <= '0;
        end else begin
            src_q  <= src_i;
            pend_q <= pend_d;
            if (wr_en) begin
                en_q <= wdata_i[NSRC-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            meip_q     <= 1'b0;
            claim_id_q <= 5'd0;
            claim_v_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enc_v) begin
                        state_q <= ST_REQ;
                        meip_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (claim_fire) begin
                        claim_id_q <= enc_id;
                        claim_v_q  <= 1'b1;
                        state_q    <= ST_SERVICE;
                        meip_q     <= 1'b0;
                    end else if (!enc_v) begin
                        claim_v_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        meip_q    <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (complete_hit) begin
                        claim_v_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    meip_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= 32'd0;
        end else if (rd_en_i) begin
            case (sel)
                REG_PENDING: rdata_q <= 32'(pend_vec);
                REG_ENABLE:  rdata_q <= 32'(en_q);
                REG_CLAIM:   rdata_q <= {claim_v_q, 26'd0, claim_id_q};
                default:     rdata_q <= 32'd0;
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign meip_o  = meip_q;

endmodule

// File: doc/ext_irq_ctrl.md
EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning the number of interrupt sources (1..31).
REQ-002 SHALL have parameter EDGE_MASK, default 8'hFF, meaning per source 1=rising-edge triggered and 0=level (active-high).
REQ-003 SHALL have port clk_i  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port src_i  input  NSRC  interrupt sources, synchronous to clk_i.
REQ-006 SHALL have port wr_en_i  input  1  register write strobe, one cycle per write.
REQ-007 SHALL have port rd_en_i  input  1  register read strobe.
REQ-008 SHALL have port addr_i  input  5  byte address, decoded on bits [4:2].
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port rdata_o  output  32  read data, registered.
REQ-011 SHALL have port meip_o  output  1  machine external interrupt request to the core's meip_i.
REQ-012 SHALL have port irq_ack_i  input  1  one-cycle interrupt acknowledge from the core's irq_ack_o.

Function
REQ-013 SHALL register src_i into src_q each cycle; edge event = src_i & ~src_q for EDGE_MASK bits.
REQ-014 SHALL set an edge source's pending bit on the edge where its event is detected; level-source pending bits SHALL equal src_i directly.
REQ-015 SHALL expose a register map: 0x00 PENDING (read; write-1-to-clear for edge bits), 0x04 ENABLE (read/write, bits [NSRC-1:0]), 0x08 CLAIM (read: bit31 valid, bits[4:0] id), 0x0C COMPLETE (write-only id), all other addresses reading 0 and ignoring writes.
REQ-016 SHALL return rdata_o one cycle after rd_en_i and hold it until the next read.
REQ-017 SHALL implement states IDLE, REQ and SERVICE.
REQ-018 In IDLE, SHALL go to REQ on the cycle (PENDING & ENABLE) != 0; meip_o SHALL be 1 exactly while in REQ, registered.
REQ-019 In REQ with irq_ack_i=1, SHALL latch claim_id = lowest-index set bit of (PENDING & ENABLE), set CLAIM.valid, clear that pending bit if it is an edge source, and go to SERVICE.
REQ-020 In REQ with (PENDING & ENABLE)=0 and no irq_ack_i, SHALL return to IDLE.
REQ-021 In REQ with irq_ack_i=1 and (PENDING & ENABLE)=0 in the same cycle, SHALL return to IDLE with CLAIM.valid=0.
REQ-022 In SERVICE, meip_o SHALL be 0; irq_ack_i SHALL be ignored; a COMPLETE write with wdata_i[4:0]==claim_id SHALL clear CLAIM.valid and go to IDLE; a mismatched id SHALL be ignored.
REQ-023 An edge event and a clear (W1C or claim) on the same bit in the same cycle SHALL leave the bit set.
REQ-024 New events during SERVICE, including for claim_id, SHALL latch in PENDING and be requested after completion.
REQ-025 Latency: src_i rising at edge k → pending at k → state REQ/meip_o=1 at k+1, provided the source is enabled.

Reset
REQ-026 On reset_i=1 at a clock edge, SHALL set state=IDLE, meip_o=0, rdata_o=0, PENDING(edge)=0, ENABLE=0, claim_id=0, CLAIM.valid=0, src_q=src_i.
REQ-027 Reset asserted in REQ or SERVICE SHALL abandon the claim with no further meip_o pulse until a new event occurs after reset.

Structure
REQ-028 Package ext_irq_pkg SHALL hold register offset constants, the state enumeration and default NSRC.
REQ-029 Sub-module irq_prio_enc SHALL implement the combinational lowest-index priority encoder (NSRC-bit vector → id + valid).

Verification
REQ-030 Edge source 3 enabled (ENABLE=0x08), src_i[3] 0→1 → PENDING=0x08, meip_o=1 next cycle; ack → CLAIM reads 0x80000003, PENDING=0x00, meip_o=0; COMPLETE=3 → IDLE.
REQ-031 Sources 5 and 2 pulse in the same cycle, ENABLE=0xFF → first claim id 2; after COMPLETE=2, meip_o reasserts; claim id 5.
REQ-032 Level source 0 (EDGE_MASK=0xFE) held high through COMPLETE=0 → meip_o reasserts one cycle after IDLE; src_i[0] dropped before complete → stays IDLE.
REQ-033 In SERVICE with claim_id=3, write COMPLETE=4 → state stays SERVICE, CLAIM.valid=1; source 3 re-pulses → serviced again after COMPLETE=3.
REQ-034 Edge event on source 1 coincident with W1C of PENDING bit 1 → PENDING reads 0x02.
REQ-035 reset_i asserted while in REQ → meip_o=0 next cycle, PENDING=0, ENABLE=0, CLAIM=0.
